// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator built from two row line buffers.
// Define WINDOW_FRAME_DONE_EN to add the frame_done pulse output.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       sof,
    input  logic [7:0] pix_in,
    output logic [7:0] px0,
    output logic [7:0] px1,
    output logic [7:0] px2,
    output logic [7:0] px3,
    output logic [7:0] px4,
    output logic [7:0] px5,
    output logic [7:0] px6,
    output logic [7:0] px7,
    output logic [7:0] px8,
`ifdef WINDOW_FRAME_DONE_EN
    output logic       frame_done,
`endif
    output logic       win_valid
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    logic [CW-1:0] col, col_eff;
    logic [RW-1:0] row, row_eff;
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb2 [IMG_WIDTH];
    logic [7:0] a, b;
    logic [7:0] w [9];
    logic [7:0] nw [9];
    logic [7:0] pxq [9];
    logic interior;
    // sof relocates the current pixel to (0,0) before any decision is made
    always_comb begin
        col_eff  = sof ? '0 : col;
        row_eff  = sof ? '0 : row;
        a        = lb2[col_eff];
        b        = lb1[col_eff];
        interior = row_eff >= RW'(2) && col_eff >= CW'(2);
        nw       = '{w[1], w[2], a, w[4], w[5], b, w[7], w[8], pix_in};
    end
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb2[col_eff] <= b;
            lb1[col_eff] <= pix_in;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            w         <= '{default: '0};
            pxq       <= '{default: '0};
`ifdef WINDOW_FRAME_DONE_EN
            frame_done <= 1'b0;
`endif
        end else begin
            win_valid <= in_valid && interior;
`ifdef WINDOW_FRAME_DONE_EN
            frame_done <= in_valid && row_eff == ROW_LAST && col_eff == COL_LAST;
`endif
            if (in_valid) begin
                w   <= nw;
                col <= col_eff == COL_LAST ? '0 : col_eff + 1'b1;
                row <= col_eff != COL_LAST ? row_eff : row_eff == ROW_LAST ? '0 : row_eff + 1'b1;
                if (interior)
                    pxq <= nw;
            end
        end
    end
    assign px0 = pxq[0];
    assign px1 = pxq[1];
    assign px2 = pxq[2];
    assign px3 = pxq[3];
    assign px4 = pxq[4];
    assign px5 = pxq[5];
    assign px6 = pxq[6];
    assign px7 = pxq[7];
    assign px8 = pxq[8];
endmodule
